reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite/RDaddr/RDdata) among NUM_REQ writeback requesters, e.g. ALU writeback, load writeback and the multi-cycle mul/div unit.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write so the register file sees a clean, glitch-free write request one cycle after acceptance.
- Optionally suppresses writes to register 0 and keeps a saturating contention counter for performance debug.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ZERO_GUARD, 1, 1 = accepted writes to address 0 are consumed but never issued to the register file.
- CNT_W, 16, width of the contention counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold_i  in  1  1 = freeze arbitration; no grants issued.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_addr_i  in  NUM_REQ*5  packed destination addresses; requester k uses bits [5k+4:5k].
- req_data_i  in  NUM_REQ*32  packed write data; requester k uses bits [32k+31:32k].
- req_ready_o  out  NUM_REQ  one-hot grant; combinational from valid, pointer and hold_i.
- RegWrite_o  out  1  registered write enable to the register file.
- RDaddr_o  out  5  registered write address.
- RDdata_o  out  32  registered write data.
- grant_id_o  out  3  registered index of the requester that produced the current RegWrite_o.
- conflict_cnt_o  out  CNT_W  saturating count of cycles with at least two valid requesters and hold_i=0.

Behaviour:
- Reset (async, rst_n=0):
  - RegWrite_o=0, RDaddr_o=0, RDdata_o=0, grant_id_o=0, conflict_cnt_o=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - req_ready_o=0 while rst_n=0.
  - An in-flight registered write is discarded.
- Handshake:
  - A transfer occurs on a rising edge when req_valid_i[k] & req_ready_o[k].
  - A requester holds valid, addr and data stable until ready.
  - Valid must not depend on ready.
- Arbitration (combinational, each cycle):
  - If hold_i=1 or no valid bits are set, req_ready_o=0.
  - Otherwise, scan from index ptr upward, wrapping modulo NUM_REQ. The first valid requester k gets req_ready_o = one-hot(k).
  - At most one ready bit is ever set.
- Pointer update:
  - On a transfer from k, ptr <= (k+1) mod NUM_REQ.
  - If there is no transfer, ptr holds.
  - Guarantees no starvation: a continuously valid requester is granted within NUM_REQ cycles.
- Output stage (1-cycle latency):
  - On a transfer from k: RDaddr_o <= addr_k, RDdata_o <= data_k, grant_id_o <= k.
  - RegWrite_o <= 1, except RegWrite_o <= 0 when ZERO_GUARD=1 and addr_k=0.
  - Cycles with no transfer: RegWrite_o <= 0; RDaddr_o, RDdata_o and grant_id_o hold their previous values.
  - The register file commits at the edge after RegWrite_o rises, so the total latency from acceptance to architectural write is 2 edges.
- Address 0 with ZERO_GUARD=1:
  - The requester still sees ready and the pointer still advances.
  - Only the register-file write is suppressed.
- Contention counter:
  - Increments by 1 on every edge where popcount(req_valid_i) >= 2 and hold_i=0.
  - Saturates at all-ones with no wrap.
- hold_i:
  - No grants are issued and the pointer freezes.
  - A registered write already in the output stage still completes (RegWrite_o pulses for one cycle regardless of hold_i).
- Reset mid-operation:
  - Takes effect immediately.
  - Requesters must re-present after reset release; nothing is replayed.

Test Plan:
- Reset check: assert rst_n=0 mid-run with RegWrite_o=1 -> all outputs are 0 immediately, ptr=0; after release, req_valid_i=3'b111 grants requester 0 first.
- Single requester: req 1 valid, addr=5, data=32'hDEADBEEF -> ready[1]=1 that cycle; next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=DEADBEEF, grant_id_o=1; following cycle RegWrite_o=0.
- Round-robin: all 3 valid continuously for 6 cycles -> grants 0,1,2,0,1,2; conflict_cnt_o increments once per cycle (6 after 6 edges).
- Zero guard: req 2 writes addr 0, data 7 -> ready[2]=1, RegWrite_o stays 0, ptr moves to 0; with ZERO_GUARD=0 -> RegWrite_o=1, RDaddr_o=0.
- Hold: hold_i=1 for 3 cycles with req 0 valid -> ready=0, ptr unchanged, conflict_cnt_o unchanged; release -> grant 0 next cycle.
- Saturation: CNT_W=4, two requesters valid for 20 cycles -> conflict_cnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NUM_REQ writeback sources.
// The winning write is registered, so the register file sees a clean request one cycle after acceptance.
module reg_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter bit ZERO_GUARD = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  hold_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*5-1:0]  req_addr_i,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  RegWrite_o,
  output logic [4:0]            RDaddr_o,
  output logic [31:0]           RDdata_o,
  output logic [2:0]            grant_id_o,
  output logic [CNT_W-1:0]      conflict_cnt_o
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_reg;
  logic [4:0]       addr_arr [NUM_REQ];
  logic [31:0]      data_arr [NUM_REQ];
  logic [3:0]       dist_arr [NUM_REQ];

  logic        win_found;
  logic [2:0]  win_idx;
  logic [3:0]  win_dist;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic [3:0]  valid_cnt;
  logic        xfer;
  logic        conflict;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr_i[gi*5 +: 5];
      assign data_arr[gi] = req_data_i[gi*32 +: 32];
      // Rotated distance from the pointer: 0 is the highest-priority slot.
      assign dist_arr[gi] = (4'(gi) >= 4'(ptr_reg)) ? (4'(gi) - 4'(ptr_reg))
                                                   : (4'(gi) + 4'(NUM_REQ) - 4'(ptr_reg));
      assign req_ready_o[gi] = rst_n & ~hold_i & win_found & (win_idx == 3'(gi));
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_dist  = 4'hF;
    win_addr  = '0;
    win_data  = '0;
    valid_cnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k]) begin
        valid_cnt = valid_cnt + 4'd1;
        if (dist_arr[k] < win_dist) begin
          win_found = 1'b1;
          win_idx   = 3'(k);
          win_dist  = dist_arr[k];
          win_addr  = addr_arr[k];
          win_data  = data_arr[k];
        end
      end
    end
  end

  assign xfer     = |req_ready_o;
  assign conflict = ~hold_i & (valid_cnt >= 4'd2);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (xfer) begin
      ptr_reg <= (win_idx == 3'(NUM_REQ - 1)) ? '0 : PTR_W'(win_idx + 3'd1);
    end
  end

  // Address/data/id still follow a guarded write to r0; only the enable is dropped.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
      grant_id_o <= '0;
    end else begin
      RegWrite_o <= xfer & ~(ZERO_GUARD && (win_addr == 5'd0));
      if (xfer) begin
        RDaddr_o   <= win_addr;
        RDdata_o   <= win_data;
        grant_id_o <= win_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != '1)) begin
      conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: stimulus pushes expected writes, a negedge monitor pops and compares.
// A second instance (no zero guard, 4-bit counter) shares the same inputs.
module tb_reg_wb_arbiter;
  localparam int N = 3;

  logic          clk;
  logic          rst_n;
  logic          hold;
  logic [N-1:0]  valid;
  logic [4:0]    a [N];
  logic [31:0]   d [N];
  logic [N*5-1:0]  addr_bus;
  logic [N*32-1:0] data_bus;

  logic [N-1:0]  ready, ready2;
  logic          we, we2;
  logic [4:0]    rd_addr, rd_addr2;
  logic [31:0]   rd_data, rd_data2;
  logic [2:0]    gid, gid2;
  logic [15:0]   cnt;
  logic [3:0]    cnt2;

  always_comb begin
    addr_bus = {a[2], a[1], a[0]};
    data_bus = {d[2], d[1], d[0]};
  end

  reg_wb_arbiter #(.NUM_REQ(N), .ZERO_GUARD(1'b1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n(rst_n), .hold_i(hold),
    .req_valid_i(valid), .req_addr_i(addr_bus), .req_data_i(data_bus),
    .req_ready_o(ready), .RegWrite_o(we), .RDaddr_o(rd_addr), .RDdata_o(rd_data),
    .grant_id_o(gid), .conflict_cnt_o(cnt)
  );

  reg_wb_arbiter #(.NUM_REQ(N), .ZERO_GUARD(1'b0), .CNT_W(4)) dut_alt (
    .clk_i(clk), .rst_n(rst_n), .hold_i(hold),
    .req_valid_i(valid), .req_addr_i(addr_bus), .req_data_i(data_bus),
    .req_ready_o(ready2), .RegWrite_o(we2), .RDaddr_o(rd_addr2), .RDdata_o(rd_data2),
    .grant_id_o(gid2), .conflict_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [2:0]  id;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp, mon_act;
  logic pend;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [2:0] id, input logic [4:0] ad, input logic [31:0] dt);
    exp_t e;
    e.we   = (ad != 5'd0);
    e.id   = id;
    e.addr = ad;
    e.data = dt;
    sb_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at one negedge must show up on the outputs at the next one.
  initial pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got write id=%0d addr=%0d, expected no write", gid, rd_addr);
        end else begin
          mon_exp = sb_q.pop_front();
          mon_act = {we, gid, rd_addr, rd_data};
          $display("write id=%0d addr=%0d data=%08h we=%0b", gid, rd_addr, rd_data, we);
          check("sb_write", 64'(mon_act), 64'(mon_exp));
        end
      end else begin
        check("idle_we", 64'(we), 64'd0);
      end
      pend = |(ready & valid);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    hold  = 1'b0;
    valid = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    #1 rst_n = 1'b0;
    #2;
    check("rst_we",   64'(we),      64'd0);
    check("rst_addr", 64'(rd_addr), 64'd0);
    check("rst_data", 64'(rd_data), 64'd0);
    check("rst_gid",  64'(gid),     64'd0);
    check("rst_cnt",  64'(cnt),     64'd0);
    valid = 3'b111;
    #1 check("rst_ready", 64'(ready), 64'd0);
    valid = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Round robin from a fresh pointer: 0,1,2,0,1,2
    a[0] = 5'd1; d[0] = 32'hA0A0A0A0;
    a[1] = 5'd2; d[1] = 32'hA1A1A1A1;
    a[2] = 5'd3; d[2] = 32'hA2A2A2A2;
    for (int i = 0; i < 6; i++) push(3'(i % 3), a[i % 3], d[i % 3]);
    tick(); valid = 3'b111;
    @(negedge clk); check("rr_first_ready", 64'(ready), 64'(3'b001));
    repeat (6) @(posedge clk);
    #1 valid = '0;
    @(negedge clk); check("rr_cnt", 64'(cnt), 64'd6);

    // Single requester
    a[1] = 5'd5; d[1] = 32'hDEADBEEF;
    push(3'd1, 5'd5, 32'hDEADBEEF);
    tick(); valid = 3'b010;
    @(negedge clk); check("single_ready", 64'(ready), 64'(3'b010));
    tick(); valid = '0;
    @(negedge clk); check("single_cnt", 64'(cnt), 64'd6);

    // Write to r0: guarded instance drops the enable, unguarded one issues it
    a[2] = 5'd0; d[2] = 32'd7;
    push(3'd2, 5'd0, 32'd7);
    tick(); valid = 3'b100;
    @(negedge clk); check("zg_ready", 64'(ready), 64'(3'b100));
    tick(); valid = '0;
    @(negedge clk);
    check("zg_off_we",   64'(we2),      64'd1);
    check("zg_off_addr", 64'(rd_addr2), 64'd0);
    check("zg_off_data", 64'(rd_data2), 64'd7);

    // Pointer must have wrapped to 0 after the r0 grant
    a[1] = 5'd9;  d[1] = 32'h11111111;
    a[2] = 5'd10; d[2] = 32'h22222222;
    push(3'd1, 5'd9, 32'h11111111);
    push(3'd2, 5'd10, 32'h22222222);
    tick(); valid = 3'b110;
    @(negedge clk); check("zg_ptr_ready", 64'(ready), 64'(3'b010));
    tick(); valid = 3'b100;
    @(negedge clk); check("pend_ready", 64'(ready), 64'(3'b100));

    // Hold for 3 cycles while two requesters wait
    push(3'd0, 5'd1, 32'hA0A0A0A0);
    push(3'd1, 5'd9, 32'h11111111);
    tick(); valid = 3'b011; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(ready), 64'd0);
      check("hold_cnt",   64'(cnt),   64'd7);
      tick();
    end
    hold = 1'b0;
    @(negedge clk); check("hold_release_ready", 64'(ready), 64'(3'b001));
    tick(); valid = 3'b010;
    @(negedge clk); check("after_hold_ready", 64'(ready), 64'(3'b010));
    tick(); valid = '0;
    @(negedge clk); check("hold_cnt_after", 64'(cnt), 64'd8);

    // Two requesters for 20 cycles: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) push(3'(i % 2), a[i % 2], d[i % 2]);
    tick(); valid = 3'b011;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("sat_mid", 64'(cnt2), 64'd15);
    check("cnt_mid", 64'(cnt),  64'd15);
    repeat (13) @(posedge clk);
    #1 valid = '0;
    @(negedge clk);
    check("sat_hold", 64'(cnt2), 64'd15);
    check("cnt_full", 64'(cnt),  64'd28);

    // Reset while RegWrite_o is high; pointer sits at 2 beforehand
    a[1] = 5'd4; d[1] = 32'd44;
    push(3'd1, 5'd4, 32'd44);
    tick(); valid = 3'b010;
    @(negedge clk); check("pre_rst_ready", 64'(ready), 64'(3'b010));
    tick(); valid = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_we",   64'(we),      64'd0);
    check("mrst_addr", 64'(rd_addr), 64'd0);
    check("mrst_data", 64'(rd_data), 64'd0);
    check("mrst_gid",  64'(gid),     64'd0);
    check("mrst_cnt",  64'(cnt),     64'd0);
    check("mrst_cnt2", 64'(cnt2),    64'd0);
    valid = 3'b111;
    #1 check("mrst_ready", 64'(ready), 64'd0);
    push(3'd0, 5'd1, 32'hA0A0A0A0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("post_rst_ready", 64'(ready), 64'(3'b001));
    tick(); valid = '0;
    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
